// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the a/b pulse-sequence transmitter.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_HIGH_CYC = 2;
  localparam int DEF_GAP_CYC  = 1;

  // Phase timer width: enough to hold max(high, gap) - 1, never narrower than one bit.
  function automatic int cnt_width(input int high_cyc, input int gap_cyc);
    int m;
    m = (high_cyc > gap_cyc) ? high_cyc : gap_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pulse_seq_timer.sv
// Loadable down-counter with terminal-count flag, shared by the HIGH and GAP phases.
module pulse_seq_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pulse_seq_tx.sv
// Pulse-sequence transmitter: sends up to MAX_LEN symbols as fixed-width pulses on a (0) / b (1).
module pulse_seq_tx
  import pulse_seq_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int HIGH_CYC = DEF_HIGH_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] sym,
  input  logic [LW-1:0]      len,
  output logic               ready,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic [LW-1:0]      idx
);

  localparam int CW = cnt_width(HIGH_CYC, GAP_CYC);

  state_t             state, next_state;
  logic [MAX_LEN-1:0] sym_r;
  logic [LW-1:0]      len_r, len_clamp, cur_idx;
  logic               latch, idx_inc, load, tc, cur_sym;
  logic [CW-1:0]      load_val;

  assign len_clamp = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  assign cur_sym   = |(sym_r & (MAX_LEN'(1) << cur_idx));

  pulse_seq_timer #(
    .W(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .load    (load),
    .load_val(load_val),
    .tc      (tc)
  );

  always_comb begin
    next_state = state;
    latch      = 1'b0;
    idx_inc    = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          latch      = 1'b1;
          next_state = (len_clamp == '0) ? DONE : HIGH;
        end
      end
      HIGH: if (tc) next_state = GAP;
      GAP: begin
        if (tc) begin
          if (cur_idx == len_r - LW'(1)) begin
            next_state = DONE;
          end else begin
            next_state = HIGH;
            idx_inc    = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    // Timer reloads on every state change with the length of the phase being entered.
    if (next_state != state) begin
      load = 1'b1;
      if (next_state == HIGH)     load_val = CW'(HIGH_CYC - 1);
      else if (next_state == GAP) load_val = CW'(GAP_CYC - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sym_r   <= '0;
      len_r   <= '0;
      cur_idx <= '0;
    end else begin
      state <= next_state;
      if (latch) begin
        sym_r   <= sym;
        len_r   <= len_clamp;
        cur_idx <= '0;
      end else if (idx_inc) begin
        cur_idx <= cur_idx + LW'(1);
      end
    end
  end

  // Outputs trail the state by one edge so every line comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b1;
      a     <= 1'b0;
      b     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
    end else begin
      ready <= (state == IDLE) && (next_state == IDLE);
      a     <= (state == HIGH) && !cur_sym;
      b     <= (state == HIGH) && cur_sym;
      busy  <= (state == HIGH) || (state == GAP);
      done  <= (state == DONE);
      idx   <= cur_idx;
    end
  end

endmodule

// File: tb/tb_pulse_seq_tx.sv
// Directed self-checking bench for pulse_seq_tx: per-edge output traces compared to hand-derived masks.
module tb_pulse_seq_tx;

  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, start1 = 1'b0;
  logic [15:0]   sym = '0, sym1 = '0;
  logic [LW-1:0] len = '0, len1 = '0;
  logic          ready, a, b, busy, done;
  logic          ready1, a1, b1, busy1, done1;
  logic [LW-1:0] idx, idx1;

  int errors = 0;
  int checks = 0;

  logic [63:0] ta, tb, td, tr, tbusy, ta1, tb1, td1;
  int          tidx [64];

  always #5 clk = ~clk;

  pulse_seq_tx #(
    .MAX_LEN (16),
    .HIGH_CYC(2),
    .GAP_CYC (1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sym(sym), .len(len),
    .ready(ready), .a(a), .b(b), .busy(busy), .done(done), .idx(idx)
  );

  pulse_seq_tx #(
    .MAX_LEN (16),
    .HIGH_CYC(3),
    .GAP_CYC (2)
  ) dut_sweep (
    .clk(clk), .reset(reset), .start(start1), .sym(sym1), .len(len1),
    .ready(ready1), .a(a1), .b(b1), .busy(busy1), .done(done1), .idx(idx1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit e of each trace is the output value just after edge e (edge 0 = edge sampling start).
  task automatic capture(input int n, input bit hold, input int poke, input bit sel);
    ta = '0; tb = '0; td = '0; tr = '0; tbusy = '0; ta1 = '0; tb1 = '0; td1 = '0;
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      #1;
      ta[e] = a; tb[e] = b; td[e] = done; tr[e] = ready; tbusy[e] = busy;
      ta1[e] = a1; tb1[e] = b1; td1[e] = done1;
      tidx[e] = int'(idx);
      if (sel) begin
        start1 = 1'b0;
      end else if (e == poke) begin
        start = 1'b1;
        sym   = ~sym;
        len   = 5'd1;
      end else begin
        start = hold;
      end
    end
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  logic [63:0] exp_b;
  int          npulse;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_a",     64'(a),     64'd0);
    check("rst_b",     64'(b),     64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_idx",   64'(idx),   64'd0);
    check("rst_sweep", {61'd0, ready1, busy1, done1}, 64'b100);
    check("rst_sweep_idx", 64'(idx1), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // sym=000A len=4; stray start with new sym/len injected after edge 5
    sym = 16'h000A; len = 5'd4; start = 1'b1;
    capture(16, 1'b0, 5, 1'b0);
    check("w4_a",     ta,      64'h186);
    check("w4_b",     tb,      64'hC30);
    check("w4_done",  td,      64'h2000);
    check("w4_ready", tr,      64'hC000);
    check("w4_busy",  tbusy,   64'h1FFE);
    check("w4_excl",  ta & tb, 64'h0);
    check("w4_idx4",  64'(tidx[4]),  64'd1);
    check("w4_idx10", 64'(tidx[10]), 64'd3);

    // len=0: done only
    sym = 16'hFFFF; len = 5'd0; start = 1'b1;
    capture(4, 1'b0, -1, 1'b0);
    check("l0_done",  td,      64'h2);
    check("l0_ready", tr,      64'hC);
    check("l0_ab",    ta | tb, 64'h0);

    // len=20 clamps to 16
    sym = 16'hFFFF; len = 5'd20; start = 1'b1;
    capture(52, 1'b0, -1, 1'b0);
    exp_b = '0;
    for (int i = 0; i < 16; i++) begin
      exp_b[1 + 3*i] = 1'b1;
      exp_b[2 + 3*i] = 1'b1;
    end
    npulse = 0;
    for (int e = 1; e < 52; e++) if (tb[e] && !tb[e-1]) npulse++;
    check("clamp_b",      tb,  exp_b);
    check("clamp_pulses", 64'(npulse), 64'd16);
    check("clamp_a",      ta,  64'h0);
    check("clamp_done",   td,  64'h1 << 49);

    // start held high continuously, len=1, sym=0
    sym = 16'h0000; len = 5'd1; start = 1'b1;
    capture(10, 1'b1, -1, 1'b0);
    check("b2b_a",    ta, 64'hC6);
    check("b2b_done", td, 64'h210);
    repeat (6) @(posedge clk);
    #1;

    // reset during the second symbol's HIGH
    sym = 16'h0002; len = 5'd3; start = 1'b1;
    capture(5, 1'b0, -1, 1'b0);
    check("mid_b_before", 64'(tb[4]), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_async", {59'd0, a, b, busy, done, ready}, 64'b00001);
    check("mid_idx",   64'(idx), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    capture(8, 1'b0, -1, 1'b0);
    check("mid_no_done", td,      64'h0);
    check("mid_no_ab",   ta | tb, 64'h0);
    sym = 16'h0002; len = 5'd2; start = 1'b1;
    capture(10, 1'b0, -1, 1'b0);
    check("rerun_a",    ta, 64'h6);
    check("rerun_b",    tb, 64'h30);
    check("rerun_done", td, 64'h80);

    // HIGH_CYC=3, GAP_CYC=2, len=2, sym=01
    sym1 = 16'h0001; len1 = 5'd2; start1 = 1'b1;
    capture(14, 1'b0, -1, 1'b1);
    check("sweep_b",    tb1, 64'hE);
    check("sweep_a",    ta1, 64'h1C0);
    check("sweep_done", td1, 64'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
